sync_fifo_param: RTL

// - Parametrised single-clock FIFO. Next generation of the team's 8x16 FIFO.
// - Adds configurable width and depth, programmable almost-full/almost-empty thresholds,
//   an optional first-word-fall-through (FWFT) read mode, and sticky overflow/underflow flags.
// - Accepted-operation accounting replaces raw-enable counting.
// - Used as the generic buffer between streaming stages in the study designs.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_dpram.sv | 26 ++
 rtl/sync_fifo_param.sv | 80 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO mode constants, clog2 and parameter legality helper
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic fifo_params_ok(input int depth, input int afull_th, input int aempty_th, input int fwft);
    return depth >= 4 && (depth & (depth - 1)) == 0 &&
           afull_th >= 1 && afull_th <= depth - 1 &&
           aempty_th >= 0 && aempty_th <= depth - 1 &&
           (fwft == FIFO_MODE_STD || fwft == FIFO_MODE_FWFT);
  endfunction
endpackage

// File: rtl/fifo_dpram.sv
// fifo_dpram: DATA_W x DEPTH simple dual-port RAM, sync write, registered read with enable
// ports: clk, rst_n (clears read register only), we/waddr/wdata write port, re/raddr/rdata read port
module fifo_dpram import fifo_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO, thresholds, optional FWFT, sticky ovf/udf
// ports: clk, rst_n (async, active-low), wr_en/din, rd_en, err_clr -> dout, dout_valid,
//        cnt, full, empty, afull, aempty, ovf, udf
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 15,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = FIFO_MODE_STD,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CW-1:0]     cnt,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic              ovf,
  output logic              udf
);
  localparam logic IS_FWFT = FWFT == FIFO_MODE_FWFT;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, mem_cnt;
  logic          dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_acc, rd_acc, load;
  if (!fifo_params_ok(DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH, threshold or FWFT parameter");
  end
  assign full   = cnt_q == CW'(DEPTH);
  assign empty  = cnt_q == '0;
  assign afull  = cnt_q >= CW'(AFULL_TH);
  assign aempty = cnt_q <= CW'(AEMPTY_TH);
  // In FWFT mode cnt counts the word parked in dout, so the RAM holds cnt - dout_valid words.
  // RAM reads (load) refill dout whenever it is empty or being popped and the RAM has data.
  always_comb begin
    wr_acc   = wr_en & !full;
    rd_acc   = rd_en & (IS_FWFT ? dv_q : !empty);
    mem_cnt  = cnt_q - CW'(dv_q);
    load     = IS_FWFT ? (mem_cnt != '0) & (!dv_q | rd_acc) : rd_acc;
    dv_d     = IS_FWFT ? load | (dv_q & !rd_acc) : rd_acc;
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(load);
    cnt_d    = cnt_q + CW'(wr_acc) - CW'(rd_acc);
    ovf_d    = (ovf_q & !err_clr) | (wr_en & full);
    udf_d    = (udf_q & !err_clr) | (rd_en & (IS_FWFT ? !dv_q : empty));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  fifo_dpram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .rst_n(rst_n),
    .we(wr_acc), .waddr(wr_ptr_q), .wdata(din),
    .re(load), .raddr(rd_ptr_q), .rdata(dout)
  );
  assign cnt        = cnt_q;
  assign dout_valid = dv_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;
endmodule
